io_handshake_ctrl: RTL and testbench
====================================

# io_handshake_ctrl

I/O responder for the single-cycle core's stall protocol. It detects decoded IN/OUT instructions and holds the PC with `input_flag`/`output_flag`. It then completes the user-side transfer: a debounced enter button and switch capture for IN, or a fixed display hold for OUT. Finally it pulses `insert` for one cycle so the PC loads its next address. It sits between the control unit, the PC, the register-file write port and the board switches, button and display.

## Interface
Parameters:
- `SW_WIDTH`, 16: switch bus width. Captured value is zero-extended to 32 bits.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a button level change.
- `OUT_HOLD_CYCLES`, 5: cycles `display_valid` stays high before release.

Ports:
- `CLK` in 1: clock. All state updates on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `is_in` in 1: current instruction is IN (from decode).
- `is_out` in 1: current instruction is OUT.
- `out_data` in 32: register value to display for OUT.
- `sw` in SW_WIDTH: board switches, quasi-static.
- `enter_btn` in 1: raw asynchronous push button, active-high.
- `input_flag` out 1: stall request to PC, IN in progress.
- `output_flag` out 1: stall request to PC, OUT in progress.
- `insert` out 1: one-cycle release pulse to PC.
- `in_data` out 32: captured switch value for register-file write.
- `in_valid` out 1: register-file write enable for `in_data`. Asserted in the same cycle as `insert` for IN.
- `display_data` out 32: value driven to the display.
- `display_valid` out 1: display-update strobe.

## Operation
- States: IDLE, IN_WAIT_PRESS, IN_WAIT_RELEASE, OUT_HOLD, RELEASE.
- `input_flag` = (state ∈ {IN_WAIT_PRESS, IN_WAIT_RELEASE}) | (state==RELEASE & rel_is_in) | (state==IDLE & is_in).
- `output_flag` = (state ∈ {OUT_HOLD}) | (state==RELEASE & !rel_is_in) | (state==IDLE & is_out & !is_in).
- Both flags are combinational, so the PC stalls in the same cycle the instruction appears. `rel_is_in` is a registered bit recording the transaction type.
- IDLE transitions:
  - `is_in` → IN_WAIT_PRESS. `is_in` has priority over `is_out` when both are set.
  - Otherwise `is_out` → OUT_HOLD, latching `display_data <= out_data` and loading the hold counter.
- IN_WAIT_PRESS: when the debounced button rises, latch `in_data <= {zero, sw}` and go to IN_WAIT_RELEASE.
- IN_WAIT_RELEASE: when the debounced button falls, go to RELEASE. A held button never produces a second capture.
- OUT_HOLD: `display_valid`=1. The counter counts OUT_HOLD_CYCLES cycles, then the state moves to RELEASE.
- RELEASE, one cycle:
  - `insert`=1.
  - `in_valid`=1 iff `rel_is_in`.
  - Flags remain high.
  - Next state is IDLE.
- Debounce:
  - `enter_btn` passes through a 2-flop synchronizer.
  - A counter resets on any change of the synchronized level. When it reaches DEBOUNCE_CYCLES, the debounced level updates.
  - Debounce runs in every state. A press made while in IDLE is not consumed by a later IN: an IN requires a fresh rising edge.
- `display_data` and `in_data` hold their last value until overwritten.
- Reset values:
  - `in_data`=0, `display_data`=0, `display_valid`=0, `insert`=0, `in_valid`=0.
  - State=IDLE, counters=0, sync/debounced=0.
  - Flags are forced to 0 while `reset`=1.
- Reset mid-transaction: the transaction is abandoned with no `insert` and no write. The sequence restarts from IDLE when `reset` falls.

## Timing
- IN latency, measured from the first cycle with `is_in`=1 in IDLE:
  - 1 cycle to IN_WAIT_PRESS.
  - Then 2 (sync) + DEBOUNCE_CYCLES after the raw press, then the capture edge.
  - Release detection takes the same delay.
  - Then 1 RELEASE cycle.
- OUT latency: exactly 1 + OUT_HOLD_CYCLES + 1 cycles from `is_out` in IDLE to the end of the `insert` cycle. With defaults this is 7.
- `insert` is never high for two consecutive cycles. It is followed by at least one IDLE cycle.
- The PC advances on the edge that ends the RELEASE cycle.

## Structure
- Shared package `io_pkg` holds:
  - the state enum `io_state_t`;
  - default constants `IO_DEBOUNCE_DEFAULT`=4 and `IO_OUT_HOLD_DEFAULT`=5.
- Sub-module `btn_debounce`, covering synchronizer plus debounce counter:
  - inputs CLK, reset and raw;
  - outputs level, rise and fall (single-cycle pulses).
- The top level holds the FSM, the hold counter and the data registers.

## Test plan
- OUT: `out_data`=0xDEADBEEF with `is_out` high in IDLE → `output_flag` high immediately; `display_data`=0xDEADBEEF with `display_valid` high for 5 cycles; `insert` in cycle 7; flags low afterward.
- IN: `sw`=0x00A5, `is_in` high, clean press held for 10 cycles, then release → exactly one cycle with `insert`=`in_valid`=1 and `in_data`=0x000000A5, at 2+4 cycles after the release.
- Bounce: press toggling every 2 cycles for 12 cycles, then stable → no capture during bouncing; one capture 6 cycles after the level settles.
- Held button: button already high before `is_in` → no capture until it is released and pressed again.
- Simultaneous `is_in` and `is_out` → IN path taken; `output_flag` stays 0; `display_data` unchanged.
- Reset asserted during IN_WAIT_RELEASE → all outputs 0 asynchronously; no `insert`; IDLE after deassert.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the I/O handshake responder.
//   io_state_t          : handshake FSM states
//   IO_DEBOUNCE_DEFAULT : default stable-sample count for the enter button
//   IO_OUT_HOLD_DEFAULT : default display hold length for OUT
package io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IN_WAIT_PRESS,
    IN_WAIT_RELEASE,
    OUT_HOLD,
    RELEASE
  } io_state_t;

  localparam int unsigned IO_DEBOUNCE_DEFAULT = 4;
  localparam int unsigned IO_OUT_HOLD_DEFAULT = 5;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a debounce counter.
//   CLK, reset : clock, asynchronous active-high reset
//   raw        : asynchronous button input
//   level      : debounced button level
//   rise, fall : single-cycle pulses in the cycle whose closing edge flips level
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          settle;

  // cnt tracks consecutive samples that differ from the accepted level; a
  // sample matching the level (i.e. any bounce back) clears it.
  assign settle = (sync2 != level) && (cnt == CNT_LAST);
  assign rise   = settle & sync2;
  assign fall   = settle & ~sync2;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_handshake_ctrl.sv
// I/O responder for the single-cycle core's stall protocol.
//   CLK, reset                 : clock, asynchronous active-high reset
//   is_in, is_out              : decoded IN / OUT instruction (IN wins if both)
//   out_data                   : register value to show for OUT
//   sw, enter_btn              : board switches and raw enter button
//   input_flag, output_flag    : combinational PC stall requests
//   insert                     : one-cycle PC release pulse
//   in_data, in_valid          : captured switches and register-file write enable
//   display_data, display_valid: display value and update strobe
module io_handshake_ctrl
  import io_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
  parameter int unsigned OUT_HOLD_CYCLES = IO_OUT_HOLD_DEFAULT
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                is_in,
  input  logic                is_out,
  input  logic [31:0]         out_data,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                enter_btn,
  output logic                input_flag,
  output logic                output_flag,
  output logic                insert,
  output logic [31:0]         in_data,
  output logic                in_valid,
  output logic [31:0]         display_data,
  output logic                display_valid
);

  localparam int unsigned HW = (OUT_HOLD_CYCLES > 1) ? $clog2(OUT_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(OUT_HOLD_CYCLES - 1);

  io_state_t     state;
  io_state_t     next_state;
  logic [HW-1:0] hold_cnt;
  logic          rel_is_in;
  logic          btn_level;
  logic          btn_rise;
  logic          btn_fall;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .CLK  (CLK),
    .reset(reset),
    .raw  (enter_btn),
    .level(btn_level),
    .rise (btn_rise),
    .fall (btn_fall)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    input_flag    = 1'b0;
    output_flag   = 1'b0;
    insert        = 1'b0;
    in_valid      = 1'b0;
    display_valid = 1'b0;
    case (state)
      IDLE: begin
        input_flag  = is_in;
        output_flag = is_out & ~is_in;
        if (is_in)       next_state = IN_WAIT_PRESS;
        else if (is_out) next_state = OUT_HOLD;
      end
      IN_WAIT_PRESS: begin
        input_flag = 1'b1;
        if (btn_rise) next_state = IN_WAIT_RELEASE;
      end
      IN_WAIT_RELEASE: begin
        input_flag = 1'b1;
        // level is high on entry, so this is fall in practice; the level term
        // keeps the state from waiting forever on an already-low button.
        if (btn_fall || !btn_level) next_state = RELEASE;
      end
      OUT_HOLD: begin
        output_flag   = 1'b1;
        display_valid = 1'b1;
        if (hold_cnt == '0) next_state = RELEASE;
      end
      RELEASE: begin
        insert      = 1'b1;
        in_valid    = rel_is_in;
        input_flag  = rel_is_in;
        output_flag = ~rel_is_in;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // IDLE decodes the flags straight from is_in/is_out, so mask them in reset.
    if (reset) begin
      input_flag  = 1'b0;
      output_flag = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      hold_cnt     <= '0;
      rel_is_in    <= 1'b0;
      in_data      <= '0;
      display_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_in) begin
            rel_is_in <= 1'b1;
          end else if (is_out) begin
            rel_is_in    <= 1'b0;
            display_data <= out_data;
            hold_cnt     <= HOLD_LOAD;
          end
        end
        IN_WAIT_PRESS: if (btn_rise) in_data <= 32'(sw);
        OUT_HOLD:      if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_handshake_ctrl.sv
module tb_io_handshake_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic        is_in;
  logic        is_out;
  logic [31:0] out_data;
  logic [15:0] sw;
  logic        enter_btn;
  logic        input_flag;
  logic        output_flag;
  logic        insert;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] display_data;
  logic        display_valid;

  int errors = 0;
  int checks = 0;

  io_handshake_ctrl #(
    .SW_WIDTH(16),
    .DEBOUNCE_CYCLES(4),
    .OUT_HOLD_CYCLES(5)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .is_in        (is_in),
    .is_out       (is_out),
    .out_data     (out_data),
    .sw           (sw),
    .enter_btn    (enter_btn),
    .input_flag   (input_flag),
    .output_flag  (output_flag),
    .insert       (insert),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .display_data (display_data),
    .display_valid(display_valid)
  );

  always #5 CLK = ~CLK;

  // advance one cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; is_in = 1'b1; is_out = 1'b1; out_data = 32'h1; sw = 16'h1; enter_btn = 1'b0;
    #2;
    checks++;
    if ({input_flag, output_flag, insert, in_valid, display_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {input_flag, output_flag, insert, in_valid, display_valid});
    end
    checks++;
    if (in_data !== 32'h0 || display_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got in=%h disp=%h want 0/0", in_data, display_data);
    end
    is_in = 1'b0; is_out = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_out();
    out_data = 32'hDEADBEEF; is_out = 1'b1;
    #1;
    checks++;
    if (output_flag !== 1'b1 || input_flag !== 1'b0) begin
      errors++;
      $display("FAIL out_flag_immediate: got out=%b in=%b want 1/0", output_flag, input_flag);
    end
    tick();
    is_out = 1'b0; out_data = 32'h0;
    for (int unsigned i = 0; i < 5; i++) begin
      checks++;
      if (display_valid !== 1'b1 || display_data !== 32'hDEADBEEF || insert !== 1'b0 || output_flag !== 1'b1) begin
        errors++;
        $display("FAIL out_hold[%0d]: got dv=%b dd=%h ins=%b of=%b want 1/deadbeef/0/1",
                 i, display_valid, display_data, insert, output_flag);
      end
      tick();
    end
    checks++;
    if (insert !== 1'b1 || in_valid !== 1'b0 || output_flag !== 1'b1 || display_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_insert: got ins=%b iv=%b of=%b dv=%b want 1/0/1/0", insert, in_valid, output_flag, display_valid);
    end
    tick();
    checks++;
    if (insert !== 1'b0 || output_flag !== 1'b0 || input_flag !== 1'b0 || display_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL out_after: got ins=%b of=%b if=%b dd=%h want 0/0/0/deadbeef", insert, output_flag, input_flag, display_data);
    end
  endtask

  // release the button and expect the insert/write cycle 6 edges later
  task automatic release_and_check(input string name, input logic [31:0] exp_data);
    enter_btn = 1'b0;
    for (int unsigned k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (insert !== 1'b0 || input_flag !== 1'b1) begin
        errors++;
        $display("FAIL %s_early_insert[%0d]: got ins=%b if=%b want 0/1", name, k, insert, input_flag);
      end
    end
    tick();
    checks++;
    if (insert !== 1'b1 || in_valid !== 1'b1 || in_data !== exp_data || output_flag !== 1'b0) begin
      errors++;
      $display("FAIL %s_insert: got ins=%b iv=%b data=%h of=%b want 1/1/%h/0", name, insert, in_valid, in_data, output_flag, exp_data);
    end
    tick();
    checks++;
    if (insert !== 1'b0 || in_valid !== 1'b0 || input_flag !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: got ins=%b iv=%b if=%b want 0/0/0", name, insert, in_valid, input_flag);
    end
  endtask

  task automatic test_in_clean();
    sw = 16'h00A5; is_in = 1'b1;
    #1;
    checks++;
    if (input_flag !== 1'b1 || output_flag !== 1'b0) begin
      errors++;
      $display("FAIL in_flag_immediate: got if=%b of=%b want 1/0", input_flag, output_flag);
    end
    tick();
    is_in = 1'b0;
    tick(); tick();
    enter_btn = 1'b1;
    for (int unsigned k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) begin
        checks++;
        if (in_data !== 32'hDEADBEEF && in_data !== 32'h0) begin
          errors++;
          $display("FAIL in_capture_early: got %h want 0", in_data);
        end
      end
      if (k == 6) begin
        checks++;
        if (in_data !== 32'h000000A5) begin
          errors++;
          $display("FAIL in_capture: got %h want 000000a5", in_data);
        end
      end
    end
    release_and_check("in_clean", 32'h000000A5);
  endtask

  task automatic test_bounce();
    sw = 16'h1234; is_in = 1'b1;
    tick();
    is_in = 1'b0;
    for (int unsigned k = 0; k < 12; k++) begin
      enter_btn = ((k / 2) % 2 == 0);
      tick();
    end
    checks++;
    if (in_data !== 32'h000000A5) begin
      errors++;
      $display("FAIL bounce_no_capture: got %h want 000000a5", in_data);
    end
    enter_btn = 1'b1;
    for (int unsigned k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        checks++;
        if (in_data !== 32'h000000A5) begin
          errors++;
          $display("FAIL bounce_early: got %h want 000000a5", in_data);
        end
      end
    end
    checks++;
    if (in_data !== 32'h00001234) begin
      errors++;
      $display("FAIL bounce_capture: got %h want 00001234", in_data);
    end
    tick(); tick();
    release_and_check("bounce", 32'h00001234);
  endtask

  task automatic test_held_button();
    enter_btn = 1'b1;
    for (int unsigned k = 0; k < 8; k++) tick();
    sw = 16'h00FF; is_in = 1'b1;
    tick();
    is_in = 1'b0;
    for (int unsigned k = 0; k < 10; k++) tick();
    checks++;
    if (in_data !== 32'h00001234 || input_flag !== 1'b1) begin
      errors++;
      $display("FAIL held_no_capture: got %h if=%b want 00001234/1", in_data, input_flag);
    end
    enter_btn = 1'b0;
    for (int unsigned k = 0; k < 8; k++) tick();
    checks++;
    if (insert !== 1'b0 || in_data !== 32'h00001234 || input_flag !== 1'b1) begin
      errors++;
      $display("FAIL held_release_ignored: got ins=%b data=%h if=%b want 0/00001234/1", insert, in_data, input_flag);
    end
    enter_btn = 1'b1;
    for (int unsigned k = 0; k < 6; k++) tick();
    checks++;
    if (in_data !== 32'h000000FF) begin
      errors++;
      $display("FAIL held_fresh_capture: got %h want 000000ff", in_data);
    end
    tick(); tick();
    release_and_check("held", 32'h000000FF);
  endtask

  task automatic test_simultaneous();
    sw = 16'h00C3; out_data = 32'h11112222; is_in = 1'b1; is_out = 1'b1;
    #1;
    checks++;
    if (input_flag !== 1'b1 || output_flag !== 1'b0) begin
      errors++;
      $display("FAIL simul_flags: got if=%b of=%b want 1/0", input_flag, output_flag);
    end
    tick();
    is_in = 1'b0; is_out = 1'b0;
    tick();
    checks++;
    if (output_flag !== 1'b0 || display_valid !== 1'b0 || display_data !== 32'hDEADBEEF || input_flag !== 1'b1) begin
      errors++;
      $display("FAIL simul_in_path: got of=%b dv=%b dd=%h if=%b want 0/0/deadbeef/1",
               output_flag, display_valid, display_data, input_flag);
    end
  endtask

  // continues the IN started by test_simultaneous
  task automatic test_reset_mid_in();
    enter_btn = 1'b1;
    for (int unsigned k = 0; k < 8; k++) tick();
    checks++;
    if (in_data !== 32'h000000C3 || input_flag !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: got %h if=%b want 000000c3/1", in_data, input_flag);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({input_flag, output_flag, insert, in_valid, display_valid} !== 5'b0 ||
        in_data !== 32'h0 || display_data !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async: got ctrl=%b in=%h disp=%h want 00000/0/0",
               {input_flag, output_flag, insert, in_valid, display_valid}, in_data, display_data);
    end
    enter_btn = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int unsigned k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (insert !== 1'b0 || in_valid !== 1'b0 || input_flag !== 1'b0) begin
        errors++;
        $display("FAIL midrst_after[%0d]: got ins=%b iv=%b if=%b want 0/0/0", k, insert, in_valid, input_flag);
      end
    end
    // IDLE after reset: a new OUT is accepted immediately
    out_data = 32'hCAFE0001; is_out = 1'b1;
    #1;
    checks++;
    if (output_flag !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: got of=%b want 1", output_flag);
    end
    tick();
    is_out = 1'b0;
    checks++;
    if (display_valid !== 1'b1 || display_data !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL midrst_out: got dv=%b dd=%h want 1/cafe0001", display_valid, display_data);
    end
  endtask

  initial begin
    test_reset();
    test_out();
    tick();
    test_in_clean();
    tick();
    test_bounce();
    tick();
    test_held_button();
    tick();
    test_simultaneous();
    test_reset_mid_in();
    for (int unsigned k = 0; k < 8; k++) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
